// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-side memory stage: funct3 size codes, FSM states,
// default LED address and the store byte-enable helper.
package data_mem_ctrl_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam logic [31:0] LED_ADDR_DEFAULT = 32'h0000_2000;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_t;

  function automatic logic [3:0] byte_en(input logic [2:0] sz, input logic [1:0] lo);
    case (sz[1:0])
      2'b00:   return 4'b0001 << lo;
      2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/data_ram_bank.sv
// 2**DEPTH_LOG2 x 32 single-port RAM, synchronous read, per-byte write enable.
// No reset so that it maps onto block RAM.
module data_ram_bank #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [3:0]            we,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] r_mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) r_mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
    rdata <= r_mem[addr];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory stage: RV32I loads/stores to on-chip RAM or the LED register.
// Stores complete in 1 cycle, loads in 2 (stall high during the first).
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] LED_ADDR   = LED_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [2:0]  size,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        err,
  output logic [7:0]  led
);

  state_t      r_state, w_next;
  logic        r_err;
  logic [7:0]  r_led;
  logic [31:0] r_rdata;
  logic [1:0]  r_addr_lo;
  logic [2:0]  r_size;
  logic        r_rd_ram, r_rd_led;

  logic        w_is_ram, w_is_led, w_misalign, w_bad, w_wr_ok;
  logic [3:0]  w_we;
  logic [31:0] w_wdata, w_ram_rdata, w_load;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_is_ram   = (addr[31:DEPTH_LOG2+2] == '0);
  assign w_is_led   = (addr == LED_ADDR);
  assign w_misalign = ((size[1:0] == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
  assign w_bad      = w_misalign || !(w_is_ram || w_is_led) || (memread && memwrite);
  // Reset gating keeps a write from landing while the FSM is forced to IDLE.
  assign w_wr_ok    = rst_n && (r_state == ST_IDLE) && memwrite && !w_misalign;
  assign w_we       = (w_wr_ok && w_is_ram) ? byte_en(size, addr[1:0]) : 4'b0000;

  always_comb begin
    w_wdata = write_data;
    case (size[1:0])
      2'b00:   w_wdata = {4{write_data[7:0]}};
      2'b01:   w_wdata = {2{write_data[15:0]}};
      default: w_wdata = write_data;
    endcase
  end

  data_ram_bank #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .addr  (addr[DEPTH_LOG2+1:2]),
    .we    (w_we),
    .wdata (w_wdata),
    .rdata (w_ram_rdata)
  );

  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (memread && !memwrite) begin
          w_next = ST_RD_WAIT;
          stall  = rst_n;
        end
      end
      ST_RD_WAIT: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_byte = w_ram_rdata[7:0];
    case (r_addr_lo)
      2'd0: w_byte = w_ram_rdata[7:0];
      2'd1: w_byte = w_ram_rdata[15:8];
      2'd2: w_byte = w_ram_rdata[23:16];
      2'd3: w_byte = w_ram_rdata[31:24];
      default: w_byte = w_ram_rdata[7:0];
    endcase
    w_half = r_addr_lo[1] ? w_ram_rdata[31:16] : w_ram_rdata[15:0];
    w_load = 32'h0;
    if (r_rd_led) begin
      w_load = {24'h0, r_led};
    end else if (r_rd_ram) begin
      case (r_size)
        SZ_B:    w_load = {{24{w_byte[7]}}, w_byte};
        SZ_BU:   w_load = {24'h0, w_byte};
        SZ_H:    w_load = {{16{w_half[15]}}, w_half};
        SZ_HU:   w_load = {16'h0, w_half};
        default: w_load = w_ram_rdata;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_err     <= 1'b0;
      r_led     <= 8'h00;
      r_rdata   <= 32'h0;
      r_addr_lo <= 2'b00;
      r_size    <= SZ_W;
      r_rd_ram  <= 1'b0;
      r_rd_led  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= (r_state == ST_IDLE) && (memread || memwrite) && w_bad;
      if (w_wr_ok && w_is_led) r_led <= write_data[7:0];
      if (r_state == ST_IDLE && w_next == ST_RD_WAIT) begin
        r_addr_lo <= addr[1:0];
        r_size    <= size;
        r_rd_ram  <= w_is_ram && !w_misalign;
        r_rd_led  <= w_is_led && !w_misalign;
      end
      if (r_state == ST_RD_WAIT) r_rdata <= w_load;
    end
  end

  // Outside RD_WAIT the last completed load result is held.
  assign read_data = (r_state == ST_RD_WAIT) ? w_load : r_rdata;
  assign err       = r_err;
  assign led       = r_led;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: stores, loads of every size, LED access,
// error pulses and reset during a pending load.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, write_data, read_data;
  logic        memwrite, memread, stall, err;
  logic [2:0]  size;
  logic [7:0]  led;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_mem_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .write_data (write_data),
    .memwrite   (memwrite),
    .memread    (memread),
    .size       (size),
    .read_data  (read_data),
    .stall      (stall),
    .err        (err),
    .led        (led)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic do_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] sz, input logic rd_too, input logic exp_err);
    addr = a; write_data = d; size = sz; memwrite = 1'b1; memread = rd_too;
    @(negedge clk);
    chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    memwrite = 1'b0; memread = 1'b0;
    @(negedge clk);
    chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    @(posedge clk); #1;
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] exp, input logic exp_err);
    addr = a; size = sz; memread = 1'b1;
    @(negedge clk);
    chk({tag, "_stall1"}, {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    memread = 1'b0; addr = 32'hFFFF_FFFC; size = 3'b000;
    @(negedge clk);
    chk({tag, "_stall2"}, {31'b0, stall}, 32'd0);
    chk({tag, "_data"}, read_data, exp);
    chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; addr = 32'h0; write_data = 32'h0; memwrite = 1'b0; memread = 1'b0;
    size = 3'b010;
    #12;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_err",   {31'b0, err},   32'd0);
    chk("rst_led",   {24'b0, led},   32'h00);
    chk("rst_rdata", read_data,      32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_stall", {31'b0, stall}, 32'd0);
    chk("idle_err",   {31'b0, err},   32'd0);
    chk("idle_led",   {24'b0, led},   32'h00);
    @(posedge clk); #1;

    do_store("sw10", 32'h10, 32'h8765_43A1, 3'b010, 1'b0, 1'b0);
    do_load ("lw10", 32'h10, 3'b010, 32'h8765_43A1, 1'b0);
    do_store("sb13", 32'h13, 32'h0000_00A1, 3'b000, 1'b0, 1'b0);
    do_load ("lb13",  32'h13, 3'b000, 32'hFFFF_FFA1, 1'b0);
    do_load ("lbu13", 32'h13, 3'b100, 32'h0000_00A1, 1'b0);
    do_load ("lw10b", 32'h10, 3'b010, 32'hA165_43A1, 1'b0);

    do_store("sw20",  32'h20, 32'h0000_0000, 3'b010, 1'b0, 1'b0);
    do_store("sh22",  32'h22, 32'h0000_8001, 3'b001, 1'b0, 1'b0);
    do_load ("lh22",  32'h22, 3'b001, 32'hFFFF_8001, 1'b0);
    do_load ("lhu22", 32'h22, 3'b101, 32'h0000_8001, 1'b0);
    do_store("sh21",  32'h21, 32'h0000_1234, 3'b001, 1'b0, 1'b1);
    do_load ("lw20",  32'h20, 3'b010, 32'h8001_0000, 1'b0);
    do_load ("lh21",  32'h21, 3'b001, 32'h0000_0000, 1'b1);

    do_store("swled", 32'h2000, 32'h0000_005A, 3'b010, 1'b0, 1'b0);
    chk("led_val", {24'b0, led}, 32'h5A);
    do_load ("lwled", 32'h2000, 3'b010, 32'h0000_005A, 1'b0);
    do_load ("lw8000", 32'h8000, 3'b010, 32'h0000_0000, 1'b1);
    do_store("sw8000", 32'h8000, 32'hDEAD_BEEF, 3'b010, 1'b0, 1'b1);

    do_store("rdwr", 32'h10, 32'h0000_0077, 3'b000, 1'b1, 1'b1);
    do_load ("lw10c", 32'h10, 3'b010, 32'hA165_4377, 1'b0);

    // Back-to-back loads, no bubble between them.
    addr = 32'h13; size = 3'b100; memread = 1'b1;
    @(negedge clk);
    chk("b2b_stall_a", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_data_a", read_data, 32'h0000_00A1);
    @(posedge clk); #1;
    addr = 32'h22; size = 3'b001;
    @(negedge clk);
    chk("b2b_stall_b", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    memread = 1'b0;
    @(negedge clk);
    chk("b2b_data_b", read_data, 32'hFFFF_8001);
    @(posedge clk); #1;

    // Reset while a load is pending.
    addr = 32'h10; size = 3'b010; memread = 1'b1;
    @(posedge clk); #1;
    memread = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_stall", {31'b0, stall}, 32'd0);
    chk("mrst_led",   {24'b0, led},   32'h00);
    chk("mrst_rdata", read_data,      32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_load ("lw10d", 32'h10, 3'b010, 32'hA165_4377, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
